// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the memory-stage access controller.
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0] ALIGN_MASK = 3'b111;

  function automatic logic is_aligned(input logic [2:0] low_bits);
    return (low_bits & ALIGN_MASK) == 3'b000;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_timeout_ctr.sv
// WAIT-state cycle counter; tc flags the last allowed cycle before a bus error.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign tc = en && (cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// Converts EX/MEM MemRead/MemWrite into a valid/ready memory transaction,
// stalling the pipeline until the response (or a timeout) completes the access.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [DATA_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              mem_stall,
  output logic              misaligned,
  output logic              bus_error,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_we,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_wdata,
  input  logic              resp_valid,
  input  logic [DATA_W-1:0] resp_rdata
);

  state_t state_q, state_d;
  logic   err_q;
  logic   cnt_clr, cnt_en, cnt_tc;
  logic   acc, aligned;
  logic   unused_addr_bits;

  assign acc              = MemRead | MemWrite;
  assign aligned          = is_aligned(address[2:0]);
  assign unused_addr_bits = ^address[DATA_W-1:ADDR_W];

  mem_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk  (clk),
    .reset(reset),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .tc   (cnt_tc)
  );

  always_comb begin
    state_d    = state_q;
    mem_stall  = 1'b0;
    misaligned = 1'b0;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc && aligned) begin
          mem_stall = 1'b1;
          state_d   = REQ;
        end else if (acc) begin
          misaligned = 1'b1;
        end
      end
      REQ: begin
        mem_stall = 1'b1;
        if (req_ready) begin
          state_d = WAIT;
          cnt_clr = 1'b1;
        end
      end
      WAIT: begin
        mem_stall = 1'b1;
        cnt_en    = 1'b1;
        if (resp_valid || cnt_tc) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign req_valid = (state_q == REQ);
  assign bus_error = (state_q == DONE) && err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      err_q     <= 1'b0;
      data_out  <= '0;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (acc && aligned) begin
            req_we    <= MemWrite;
            req_addr  <= address[ADDR_W-1:0];
            req_wdata <= data_in;
            err_q     <= 1'b0;
          end else if (acc) begin
            data_out <= '0;
          end
        end
        WAIT: begin
          // A response on the terminal cycle still wins over the timeout.
          if (resp_valid) begin
            if (!req_we) data_out <= resp_rdata;
          end else if (cnt_tc) begin
            data_out <= '0;
            err_q    <= 1'b1;
          end
        end
        DONE: err_q <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
